// File: rtl/ps2_fifo.sv
// rtl/ps2_fifo.sv - show-ahead keyboard character FIFO between PS/2 decoder and CPU bus
// Define PS2_FIFO_OVERWRITE_EN to overwrite the oldest entry on a full-FIFO write instead of dropping.
module ps2_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps2_write,
  input  logic [DATA_W-1:0] ps2_ascii,
  input  logic              cpu_read,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] char,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [31:0]       ps2_counter
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              is_empty;
  logic              is_full;
  logic              rd_acc;
  logic              wr_acc;
  logic              pop;
  logic              ovf_set;

  assign is_empty = (count == '0);
  assign is_full  = (count == FULL_CNT);
  assign rd_acc   = cpu_read && !is_empty;
  // A write into a full FIFO with no read is the only overflow event in either build.
  assign ovf_set  = ps2_write && is_full && !cpu_read;

`ifdef PS2_FIFO_OVERWRITE_EN
  assign wr_acc = ps2_write;
  assign pop    = rd_acc || ovf_set;
`else
  assign wr_acc = ps2_write && (!is_full || cpu_read);
  assign pop    = rd_acc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      ps2_counter <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr      <= wr_ptr + 1'b1;
        ps2_counter <= ps2_counter + 32'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[wr_ptr] <= ps2_ascii;
    end
  end

  always_comb begin
    char  = '0;
    state = 2'b01;
    if (!is_empty) begin
      char = mem[rd_ptr];
    end
    if (is_empty) begin
      state = 2'b00;
    end else if (is_full) begin
      state = 2'b10;
    end
  end

endmodule

// File: tb/tb_ps2_fifo.sv
// tb/tb_ps2_fifo.sv - self-checking bench for ps2_fifo with a queue-based reference model
// Define PS2_FIFO_OVERWRITE_EN to check the overwrite-oldest build.
module tb_ps2_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ps2_write = 1'b0;
  logic [DATA_W-1:0] ps2_ascii = '0;
  logic              cpu_read = 1'b0;
  logic              ovf_clr = 1'b0;
  logic [DATA_W-1:0] char;
  logic [1:0]        state;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic [31:0]       ps2_counter;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [DATA_W-1:0] mq[$];
  bit                m_ovf;
  logic [31:0]       m_cnt;

  ps2_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_write(ps2_write), .ps2_ascii(ps2_ascii),
    .cpu_read(cpu_read), .ovf_clr(ovf_clr), .char(char), .state(state),
    .count(count), .overflow(overflow), .ps2_counter(ps2_counter)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue with the FIFO's acceptance rules.
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_cnt = 32'd0;
    end else begin
      bit did_read;
      bit did_write;
      did_read  = cpu_read && (mq.size() > 0);
      did_write = ps2_write && ((mq.size() < DEPTH) || did_read);
      if (did_read) void'(mq.pop_front());
      if (did_write) begin
        mq.push_back(ps2_ascii);
        m_cnt = m_cnt + 32'd1;
      end else if (ps2_write) begin
`ifdef PS2_FIFO_OVERWRITE_EN
        void'(mq.pop_front());
        mq.push_back(ps2_ascii);
        m_cnt = m_cnt + 32'd1;
`endif
        m_ovf = 1'b1;
      end else if (ovf_clr) begin
        m_ovf = 1'b0;
      end
      if (ps2_write && did_write && ovf_clr) m_ovf = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [DATA_W-1:0] e_char;
      logic [1:0]        e_state;
      e_char  = (mq.size() > 0) ? mq[0] : '0;
      e_state = (mq.size() == 0) ? 2'b00 : (mq.size() == DEPTH) ? 2'b10 : 2'b01;
      chk("model_char", 32'(char), 32'(e_char));
      chk("model_state", 32'(state), 32'(e_state));
      chk("model_count", 32'(count), 32'(mq.size()));
      chk("model_overflow", 32'(overflow), 32'(m_ovf));
      chk("model_counter", ps2_counter, m_cnt);
    end
  end

  task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit c);
    ps2_write = w;
    ps2_ascii = d;
    cpu_read  = r;
    ovf_clr   = c;
    @(posedge clk);
    #2;
    ps2_write = 1'b0;
    cpu_read  = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(0, 8'h00, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h30 + i), 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);
    chk_en = 1'b1;
    rst_n = 1'b1;
    cyc(0, 8'h00, 0, 0);
    chk("rst_char", 32'(char), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_counter", ps2_counter, 32'h0);
    cyc(0, 8'h00, 1, 0);
    chk("empty_read_count", 32'(count), 32'h0);
    chk("empty_read_state", 32'(state), 32'h0);

    cyc(1, 8'h41, 0, 0);
    cyc(1, 8'h42, 0, 0);
    cyc(1, 8'h43, 0, 0);
    chk("abc_char", 32'(char), 32'h41);
    chk("abc_count", 32'(count), 32'h3);
    chk("abc_state", 32'(state), 32'h1);
    chk("abc_counter", ps2_counter, 32'h3);
    cyc(0, 8'h00, 1, 0);
    chk("pop1_char", 32'(char), 32'h42);
    cyc(0, 8'h00, 1, 0);
    chk("pop2_char", 32'(char), 32'h43);
    cyc(0, 8'h00, 1, 0);
    chk("pop3_char", 32'(char), 32'h0);
    chk("pop3_state", 32'(state), 32'h0);

    do_reset();
    fill16();
    chk("full_state", 32'(state), 32'h2);
    chk("full_count", 32'(count), 32'd16);
    cyc(1, 8'h40, 0, 0);
    chk("ovf_overflow", 32'(overflow), 32'h1);
`ifdef PS2_FIFO_OVERWRITE_EN
    chk("ovw_char", 32'(char), 32'h31);
    chk("ovw_counter", ps2_counter, 32'd17);
`else
    chk("drop_char", 32'(char), 32'h30);
    chk("drop_counter", ps2_counter, 32'd16);
`endif
    cyc(0, 8'h00, 0, 1);
    chk("ovf_clr_alone", 32'(overflow), 32'h0);

    cyc(1, 8'h55, 1, 0);
    chk("full_rw_count", 32'(count), 32'd16);
    chk("full_rw_overflow", 32'(overflow), 32'h0);
`ifdef PS2_FIFO_OVERWRITE_EN
    chk("full_rw_char", 32'(char), 32'h32);
`else
    chk("full_rw_char", 32'(char), 32'h31);
`endif
    for (int i = 0; i < 15; i++) cyc(0, 8'h00, 1, 0);
    chk("wrap_last_char", 32'(char), 32'h55);
    cyc(0, 8'h00, 1, 0);
    chk("wrap_empty_state", 32'(state), 32'h0);

    do_reset();
    cyc(1, 8'h61, 1, 0);
    chk("empty_rw_count", 32'(count), 32'h1);
    chk("empty_rw_char", 32'(char), 32'h61);
    chk("empty_rw_counter", ps2_counter, 32'h1);

    do_reset();
    fill16();
    cyc(1, 8'h77, 0, 1);
    chk("ovf_set_beats_clr", 32'(overflow), 32'h1);
    cyc(0, 8'h00, 0, 1);
    chk("ovf_clr_after", 32'(overflow), 32'h0);
    cyc(1, 8'h78, 0, 0);

    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h70 + i), 0, 0);
    rst_n = 1'b0;
    cyc(1, 8'h99, 0, 0);
    rst_n = 1'b1;
    chk("midrst_count", 32'(count), 32'h0);
    chk("midrst_char", 32'(char), 32'h0);
    chk("midrst_counter", ps2_counter, 32'h0);
    chk("midrst_overflow", 32'(overflow), 32'h0);

    for (int i = 0; i < 300; i++) begin
      cyc(bit'($urandom_range(0, 2) != 0), 8'($urandom), bit'($urandom_range(0, 2) == 0),
          bit'($urandom_range(0, 7) == 0));
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
